// File: rtl/rxuart.sv
// 8N1 UART receiver. Oversamples the asynchronous RX line with the system
// clock, samples the middle of each bit, assembles the byte LSB-first and
// presents it with a single-cycle write strobe (or a frame-error strobe).
`timescale 1ns/1ps
module rxuart #(
  parameter int CLOCKS_PER_BAUD = 139
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_wr,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLOCKS_PER_BAUD - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rx_s1;
  logic             rx_s2;
  logic [1:0]       settle;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             cnt_zero;
  logic             load_half;
  logic             load_full;
  logic             shift_en;
  logic             clr_idx;
  logic             wr_nxt;
  logic             err_nxt;
  logic             busy;

  assign cnt_zero = (cnt == '0);
  assign o_busy   = busy;

  // Two-flop synchroniser plus a settle flag: the flops reset to 1, so the
  // first two post-reset values of rx_s2 do not reflect the real line and
  // must not release WAIT_IDLE while the line may still be low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      settle <= 2'b00;
    end else begin
      rx_s1  <= i_uart_rx;
      rx_s2  <= rx_s1;
      settle <= {settle[0], 1'b1};
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= WAIT_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; every decision is taken on the synchronised line.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_IDLE: if (settle[1] && rx_s2) state_nxt = IDLE;
      IDLE:      if (!rx_s2) state_nxt = START;
      START:     if (cnt_zero) state_nxt = rx_s2 ? IDLE : DATA;
      DATA:      if (cnt_zero && (bit_idx == 3'd7)) state_nxt = STOP;
      STOP:      if (cnt_zero) state_nxt = rx_s2 ? IDLE : WAIT_IDLE;
      default:   state_nxt = WAIT_IDLE;
    endcase
  end

  // Output / datapath-control decode per state.
  always_comb begin
    busy      = 1'b1;
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    clr_idx   = 1'b0;
    wr_nxt    = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        load_half = !rx_s2;
      end
      START: begin
        if (cnt_zero && !rx_s2) begin
          load_full = 1'b1;
          clr_idx   = 1'b1;
        end
      end
      DATA: begin
        if (cnt_zero) begin
          shift_en  = 1'b1;
          load_full = 1'b1;
        end
      end
      STOP: begin
        if (cnt_zero) begin
          wr_nxt  = rx_s2;
          err_nxt = !rx_s2;
        end
      end
      default: ;
    endcase
  end

  // Bit-timing counter, bit index, registered strobes and output byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt         <= '0;
      bit_idx     <= 3'd0;
      o_wr        <= 1'b0;
      o_frame_err <= 1'b0;
      o_data      <= 8'h00;
    end else begin
      if (load_half)      cnt <= HALF_LOAD;
      else if (load_full) cnt <= FULL_LOAD;
      else if (!cnt_zero) cnt <= cnt - CNT_W'(1);
      if (clr_idx)       bit_idx <= 3'd0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      o_wr        <= wr_nxt;
      o_frame_err <= err_nxt;
      if (wr_nxt) o_data <= shift_reg;
    end
  end

  // Receive shift register: LSB arrives first, so shift right from the MSB.
  always_ff @(posedge i_clk) begin
    if (shift_en) shift_reg <= {rx_s2, shift_reg[7:1]};
  end

endmodule

// File: doc/rxuart.md
Name: rxuart

Overview:
- 8N1 UART receiver; the receive-side counterpart of txuart.
- Oversamples the asynchronous serial line with the system clock, recovers each byte LSB-first, and presents it with a one-cycle valid strobe.
- Sits between the board RX pin and the consumer logic (echo/loopback, command parser).
- Bit timing is fixed by parameter; there is no runtime baud programming.

Parameters:
- CLOCKS_PER_BAUD, 139, i_clk cycles per bit (16 MHz / 115200). Legal range >= 4; the counter is $clog2(CLOCKS_PER_BAUD) bits wide.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_uart_rx  input  1  raw serial line, idle high, asynchronous to i_clk.
- o_data  output  8  last correctly received byte; held until the next good byte.
- o_wr  output  1  one-cycle strobe; o_data is valid and newly updated in that cycle.
- o_frame_err  output  1  one-cycle strobe when the stop bit samples 0.
- o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - o_data=0x00, o_wr=0, o_frame_err=0, o_busy=1.
  - Both synchroniser flops set to 1.
  - FSM goes to WAIT_IDLE.
- Synchroniser: a two-flop chain (rx_s1 -> rx_s2). The FSM only ever looks at rx_s2.
- Definitions: H = CLOCKS_PER_BAUD/2 (integer division), B = CLOCKS_PER_BAUD. The down-counter performs its action on the cycle it reaches 0.
- WAIT_IDLE: when rx_s2=1, go to IDLE. Purpose: a reset or break in mid-frame never decodes line-low as a start bit.
- IDLE (o_busy=0): when rx_s2=0, load counter=H-1 and go to START.
- START: at counter 0, sample rx_s2.
  - Sample 1 (glitch): go to IDLE; no strobe.
  - Sample 0: load B-1, clear bit index, go to DATA.
- DATA: at each counter 0:
  - Shift rx_s2 into the MSB of the shift register (right shift).
  - Increment bit index and reload B-1.
  - After the 8th bit, go to STOP.
- STOP: at counter 0, sample rx_s2.
  - Sample 1: o_data <= shift register, o_wr=1 for the next cycle, go to IDLE.
  - Sample 0: o_frame_err=1 for the next cycle, o_data unchanged, go to WAIT_IDLE.
- Decision point: the FSM returns to IDLE at mid-stop-bit, so a following start edge about B/2 later is caught. This provides resync margin.
- Latency: let t0 be the edge at which rx_s1 first captures 0.
  - START is entered at t0+2.
  - Start-bit sample at t0+2+H.
  - Data bit k (0..7) sampled at t0+2+H+(k+1)B.
  - Stop bit sampled at t0+2+H+9B; o_wr/o_frame_err are high during the following cycle.
- Strobe rules: o_wr and o_frame_err are never high together, and each is high for exactly one cycle per frame.
- No backpressure: the consumer must take o_data on o_wr. o_data changes only on a good frame.
- Reset mid-frame: the frame is aborted with no strobe. After release, decoding resumes only once the line has been seen high.
- A line held low (break) yields exactly one o_frame_err, then o_busy stays high until the line returns high.

Test Plan (CLOCKS_PER_BAUD=16, so H=8, B=16; stimulus driven at exact bit times):
- Single byte 0x48 (bits LSB-first 0,0,0,1,0,0,1,0) -> o_wr for exactly one cycle at t0+155 (sample at t0+154). o_data=0x48, o_frame_err never high, o_busy falls at the same edge as the stop-bit sample.
- Back-to-back 0x48 then 0x65 with one stop bit -> two o_wr pulses exactly 160 cycles apart, o_data 0x48 then 0x65. Repeat with 0x00 and 0xFF -> correct values.
- Glitch: line low for 3 cycles, then high -> no o_wr, no o_frame_err. o_busy high for 8 cycles (H) then back to 0, and o_data is unchanged.
- Framing error: valid 0x55 frame with stop bit 0, then line held low for 40 bit times -> exactly one o_frame_err pulse, no o_wr, o_data keeps its previous value. o_busy stays 1 until the line rises; a subsequent good 0xA5 frame is received correctly.
- Reset mid-frame: assert i_rst_n=0 asynchronously (off a clock edge) during data bit 3 of a frame -> outputs immediately at reset values, no strobe for the aborted frame. With the line still low after release, o_busy=1 and no decode occurs; after the line goes high, a fresh 0x3C frame gives o_wr with o_data=0x3C.
- Baud tolerance: send 0xC3 with a bit period of 15 cycles and then 17 cycles -> o_wr with o_data=0xC3 both times, and no o_frame_err.
